obi_ahb3lite_bridge: RTL

- Converts the core-side req/gnt/rvalid data bus into a single-master AHB3-lite transfer sequence for one peripheral slave, such as a timer.
- Sits directly downstream of the address-decoding bus mux. One instance goes on each AHB3-lite slave port (tm0, tm1).
- Handles the AHB address/data phases, slave wait states, two-cycle ERROR responses and byte-enable-to-HSIZE translation.
- Allows exactly one outstanding transfer.

---
 rtl/obi_ahb3lite_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/obi_ahb3lite_bridge.sv
// Bridge from the core-side req/gnt/rvalid bus to a single AHB3-lite slave.
// Allows one outstanding transfer and translates byte enables to HSIZE/HADDR[1:0].
module obi_ahb3lite_bridge #(
  parameter int         AW        = 32,
  parameter int         DW        = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          gnt_o,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          HSEL,
  output logic [AW-1:0] HADDR,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [1:0]    HTRANS,
  output logic          HMASTLOCK,
  output logic [DW-1:0] HWDATA,
  input  logic [DW-1:0] HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    BADBE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       be_legal;
  logic [2:0] be_size;
  logic [1:0] be_offset;
  logic       data_write;

  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // Decode the byte-enable pattern into an AHB size and low address bits.
  always_comb begin
    be_legal  = 1'b1;
    be_size   = 3'b000;
    be_offset = 2'b00;
    case (be_i)
      4'b1111: be_size = 3'b010;
      4'b0011: be_size = 3'b001;
      4'b1100: begin be_size = 3'b001; be_offset = 2'b10; end
      4'b0001: be_offset = 2'b00;
      4'b0010: be_offset = 2'b01;
      4'b0100: be_offset = 2'b10;
      4'b1000: be_offset = 2'b11;
      default: be_legal = 1'b0;
    endcase
  end

  // Next-state logic and the combinational grant / AHB address phase; all quiet during reset.
  always_comb begin
    state_next = state;
    gnt_o      = 1'b0;
    HSEL       = 1'b0;
    HTRANS     = TRANS_IDLE;
    HWRITE     = 1'b0;
    HADDR      = '0;
    HSIZE      = 3'b000;
    if (!Rst) begin
      case (state)
        IDLE: begin
          if (req_i) begin
            if (!be_legal) begin
              gnt_o      = 1'b1;
              state_next = BADBE;
            end else if (HREADY) begin
              gnt_o      = 1'b1;
              HSEL       = 1'b1;
              HTRANS     = TRANS_NONSEQ;
              HWRITE     = we_i;
              HADDR      = {addr_i[AW-1:2], be_offset};
              HSIZE      = be_size;
              state_next = DATA;
            end
          end
        end
        DATA: begin
          if (HREADY) state_next = IDLE;
        end
        BADBE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Write data capture and the registered response strobe, data and error.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      HWDATA     <= '0;
      data_write <= 1'b0;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
      rdata_o    <= '0;
    end else begin
      rvalid_o <= 1'b0;
      if (state == IDLE && gnt_o) begin
        if (be_legal) begin
          HWDATA     <= wdata_i;
          data_write <= we_i;
        end else begin
          rvalid_o <= 1'b1;
          err_o    <= 1'b1;
          rdata_o  <= '0;
        end
      end
      if (state == DATA && HREADY) begin
        rvalid_o <= 1'b1;
        err_o    <= HRESP;
        rdata_o  <= data_write ? '0 : HRDATA;
      end
    end
  end

endmodule
